// File: rtl/reg_dump_stream.sv
// reg_dump_stream: snapshot a flattened register file on request and stream it
// out one word per valid/ready handshake, tagged with register index and last.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-low reset
//   start             dump request, only honoured while idle
//   regs_flat         register k at bits [k*XLEN +: XLEN], register 0 in the LSBs
//   busy              dump in progress
//   out_valid/ready   stream handshake
//   out_idx/data/last current word: register number, snapshot value, final-word flag
//   done              one-cycle pulse after the final word transfers
//   dump_count        completed dumps, saturating at 16'hFFFF
//
// Optional build macro DUMP_AUTO_EN: any change on regs_flat also triggers a dump;
// a change seen mid-dump is remembered and starts the next dump in the done cycle.

module reg_dump_stream #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned XLEN     = 32,
    parameter int unsigned IDX_W    = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [NUM_REGS*XLEN-1:0] regs_flat,
    output logic                     busy,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [IDX_W-1:0]         out_idx,
    output logic [XLEN-1:0]          out_data,
    output logic                     out_last,
    output logic                     done,
    output logic [15:0]              dump_count
);

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_REGS - 1);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   snap_q [NUM_REGS];
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              done_q, done_d;
    logic [15:0]       count_q, count_d;
    logic              load;
    logic              trigger;
    logic              is_last;

    assign is_last = (idx_q == LastIdx);

`ifdef DUMP_AUTO_EN
    logic [NUM_REGS*XLEN-1:0] prev_regs_q;
    logic                     pending_q, pending_d;
    logic                     change;

    assign change  = (regs_flat != prev_regs_q);
    assign trigger = start | change | pending_q;

    always_comb begin
        pending_d = pending_q;
        if (load) begin
            pending_d = 1'b0;
        end else if (state_q == StSend && change) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_regs_q <= '0;
            pending_q   <= 1'b0;
        end else begin
            prev_regs_q <= regs_flat;
            pending_q   <= pending_d;
        end
    end
`else
    assign trigger = start;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath next values
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        count_d = count_q;
        load    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (trigger) begin
                    state_d = StSend;
                    idx_d   = '0;
                    load    = 1'b1;
                end
            end
            StSend: begin
                if (out_ready) begin
                    if (is_last) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                        if (count_q != 16'hFFFF) begin
                            count_d = count_q + 16'd1;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q   <= '0;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            idx_q   <= idx_d;
            done_q  <= done_d;
            count_q <= count_d;
        end
    end

    // Snapshot is only written on the trigger edge, so regs_flat may move freely mid-dump
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                snap_q[k] <= '0;
            end
        end else if (load) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                snap_q[k] <= regs_flat[k*XLEN +: XLEN];
            end
        end
    end

    // Outputs; stream fields forced to zero outside SEND
    always_comb begin
        busy       = (state_q == StSend);
        out_valid  = (state_q == StSend);
        out_idx    = '0;
        out_data   = '0;
        out_last   = 1'b0;
        if (state_q == StSend) begin
            out_idx  = idx_q;
            out_data = snap_q[idx_q];
            out_last = is_last;
        end
        done       = done_q;
        dump_count = count_q;
    end

endmodule

// File: doc/reg_dump_stream.md
Name: reg_dump_stream

Overview:
- Downstream consumer of the RISC-V datapath top (`main`). Takes its 32 architectural register outputs, concatenated.
- On a trigger, takes an atomic snapshot of all registers. Then streams them out one word per valid/ready handshake, with index and last flag.
- Feeds a host-side logger or serial bridge, so register state can be inspected without probing 32 buses.

Parameters:
- NUM_REGS, 32, number of registers snapshotted and streamed.
- XLEN, 32, width of each register word.
- IDX_W, 5, width of the index output; must satisfy 2**IDX_W >= NUM_REGS.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  dump request, sampled only in IDLE.
- regs_flat  in  NUM_REGS*XLEN  register file contents; register k occupies bits [k*XLEN +: XLEN]. Register 0 is in the LSBs.
- busy  out  1  high while a dump is in progress.
- out_valid  out  1  stream word valid.
- out_ready  in  1  consumer ready.
- out_idx  out  IDX_W  register number of the current word.
- out_data  out  XLEN  register value from the snapshot.
- out_last  out  1  high on the word with out_idx = NUM_REGS-1.
- done  out  1  one-cycle pulse after the final word transfers.
- dump_count  out  16  number of completed dumps, saturating.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; busy=0; out_valid=0; out_idx=0; out_data=0; out_last=0; done=0; dump_count=0; snapshot cleared to 0.
  - A reset mid-dump aborts it immediately. No done pulse; dump_count is not incremented.
- States: IDLE, SEND.
- IDLE:
  - busy=0, out_valid=0.
  - If start=1 at a rising edge: snapshot <= regs_flat, idx <= 0, go to SEND.
  - First out_valid appears the cycle after start is sampled (latency 1).
- SEND:
  - busy=1, out_valid=1, out_data=snapshot[idx], out_idx=idx, out_last=(idx==NUM_REGS-1).
  - A transfer occurs when out_valid & out_ready at a rising edge.
  - Transfer with out_last=0: idx increments.
  - Transfer with out_last=1: go to IDLE; done=1 for exactly the next cycle; dump_count += 1, holding at 16'hFFFF.
- Stall rules: while out_valid=1 and out_ready=0, out_data, out_idx and out_last hold stable. out_valid never drops before its transfer.
- Snapshot isolation: changes on regs_flat during SEND do not affect streamed data.
- start during SEND is ignored; requests are not queued, except as defined under DUMP_AUTO_EN.
  - start in the same cycle as the final transfer is also ignored.
- Back-to-back dumps: earliest restart is start sampled in the cycle where done=1. Minimum dump period is NUM_REGS+1 cycles with out_ready held at 1.
- out_ready is ignored when out_valid=0.
- Register 0 is streamed as captured; no special-casing.
- done and out_valid are never high in the same cycle.

Optional Feature:
- Macro: DUMP_AUTO_EN.
- When defined:
  - A register prev_regs (NUM_REGS*XLEN, reset to 0) loads regs_flat every cycle.
  - change = (regs_flat != prev_regs).
  - In IDLE, start OR change OR pending triggers a dump, snapshotting the current regs_flat.
  - A change seen during SEND sets a pending flag. pending clears when the next dump starts and resets to 0.
  - The dump following a pending trigger begins in the cycle after done, i.e. start is sampled in the done cycle.
- When undefined: only start triggers a dump; no prev_regs or pending logic exists.

Test Plan:
- Basic dump:
  - Stimulus: after reset, regs_flat holds reg k = 32'h100+k. Pulse start for one cycle; out_ready held at 1.
  - Required: 32 consecutive words, idx 0..31, data 0x100..0x11F; out_last only at idx 31; done pulse one cycle later; dump_count=1.
- Backpressure:
  - Stimulus: toggle out_ready 1/0 every cycle, with reg7=32'h5.
  - Required: every word is delivered exactly once and in order. Word idx 7 data = 32'h5, held stable across its stall cycles. Total dump time is about 64 cycles.
- Snapshot isolation and ignored start:
  - Stimulus: start a dump, then at word 3 change reg20 to 32'hDEAD and pulse start.
  - Required: idx 20 streams the old value. No second dump (DUMP_AUTO_EN undefined). dump_count=1.
- Reset mid-dump:
  - Stimulus: assert rst=0 at word 10, asynchronously between edges.
  - Required: out_valid, busy and out_idx go to 0 immediately; no done pulse; dump_count=0. A new start after release streams from idx 0.
- Saturation:
  - Stimulus: force 65535 completed dumps (or a shortened run with dump_count preloaded via bench force), then one more dump.
  - Required: dump_count stays 16'hFFFF.
- DUMP_AUTO_EN:
  - Stimulus: change reg7 from 0 to 32'h5 with start=0. Then change reg3 during the resulting dump.
  - Required: a dump begins with word 7 = 32'h5. A second dump starts in the done cycle and shows the new reg3.
